mips_multicycle_ctrl: RTL and testbench

Main control state machine for the multi-cycle MIPS datapath variant. It sequences fetch, decode, execute, memory and write-back over several clocks and drives every datapath enable and mux select. It also produces the 2-bit `ALUOp` consumed by the existing ALU control decoder, and it stalls on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mips_multicycle_ctrl_if.sv | 33 +++
 rtl/mips_mc_outdec.sv | 84 ++++++++
 rtl/mips_multicycle_ctrl.sv | 79 +++++++
 tb/tb_mips_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the main control FSM (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [OPCODE_W-1:0] Opcode;
    logic                Zero;
    logic                MemReady;
    logic                MemReq;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                PCWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [SEL_W-1:0]    ALUSrcB;
    logic [SEL_W-1:0]    ALUOp;
    logic [SEL_W-1:0]    PCSrc;
    logic                IllegalOp;

    modport master (
        input  Opcode, Zero, MemReady,
        output MemReq, IorD, MemWrite, IRWrite, PCWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  MemReq, IorD, MemWrite, IRWrite, PCWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp
    );
endinterface

// File: rtl/mips_mc_outdec.sv
// Moore output decode for the main control FSM; FETCH and BRANCH write-enables are
// qualified by the memory handshake and the ALU zero flag respectively.
module mips_mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t           state,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [SEL_W-1:0] alu_src_b,
    output logic [SEL_W-1:0] alu_op,
    output logic [SEL_W-1:0] pc_src
);

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMMSH2;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction
// and stalls on the memory-ready handshake.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    state_t state;
    state_t state_nxt;
    logic   is_load;
    logic   illegal_c;
    logic   ready_gated_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Opcode is only valid in DECODE, so remember lw vs sw for MEMADR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 is_load <= 1'b0;
        else if (state == S_DECODE) is_load <= (bus.Opcode == OP_LW);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        illegal_c = 1'b0;
        case (state)
            S_FETCH:  if (bus.MemReady) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        state_nxt = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_nxt = is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.MemReady) state_nxt = S_MEMWB;
            S_MEMWR:  if (bus.MemReady) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // During reset FETCH must not complete, so hide MemReady from the decode
    assign ready_gated_c = bus.MemReady & rst_n;
    assign bus.IllegalOp = illegal_c;

    mips_mc_outdec u_outdec (
        .state      (state),
        .zero       (bus.Zero),
        .mem_ready  (ready_gated_c),
        .mem_req    (bus.MemReq),
        .iord       (bus.IorD),
        .mem_write  (bus.MemWrite),
        .ir_write   (bus.IRWrite),
        .pc_write   (bus.PCWrite),
        .reg_dst    (bus.RegDst),
        .mem_to_reg (bus.MemtoReg),
        .reg_write  (bus.RegWrite),
        .alu_src_a  (bus.ALUSrcA),
        .alu_src_b  (bus.ALUSrcB),
        .alu_op     (bus.ALUOp),
        .pc_src     (bus.PCSrc)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected control traces built from the
// instruction-level behaviour, with randomized wait states, opcodes and flags.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} phase_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic prev_sig = 1'b0;
    int   lat_cnt  = 0;
    bit   armed    = 1'b0;
    int   lat_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ ||
               op == T_ADDI || op == T_J;
    endfunction

    // Zero-wait clocks per instruction class
    function automatic int base_lat(input logic [5:0] op);
        case (op)
            T_BEQ, T_J:             return 3;
            T_RTYPE, T_ADDI, T_SW:  return 4;
            T_LW:                   return 5;
            default:                return 2;
        endcase
    endfunction

    // Expected control vector for a cycle of a given instruction phase
    function automatic logic [15:0] expect_vec(input phase_t ph, input logic rdy,
                                               input logic z, input logic ill);
        logic memreq, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite, srca, ill_o;
        logic [1:0] srcb, aluop, pcsrc;
        {memreq, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite, srca, ill_o} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        case (ph)
            P_FETCH:  begin memreq = 1; srcb = 2'b01; irwrite = rdy; pcwrite = rdy; end
            P_DECODE: begin srcb = 2'b11; ill_o = ill; end
            P_MEMADR, P_ADDIEX: begin srca = 1; srcb = 2'b10; end
            P_MEMRD:  begin memreq = 1; iord = 1; end
            P_MEMWB:  begin memtoreg = 1; regwrite = 1; end
            P_MEMWR:  begin memreq = 1; iord = 1; memwrite = 1; end
            P_EXEC:   begin srca = 1; aluop = 2'b10; end
            P_ALUWB:  begin regdst = 1; regwrite = 1; end
            P_BRANCH: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcwrite = z; end
            P_ADDIWB: regwrite = 1;
            P_JUMP:   begin pcsrc = 2'b10; pcwrite = 1; end
            default: ;
        endcase
        return {memreq, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite,
                srca, srcb, aluop, pcsrc, ill_o};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {bus.MemReq, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
                bus.IllegalOp};
    endfunction

    // Measures clocks between successive FETCH entries as seen on the outputs
    task automatic track_latency();
        logic sig;
        sig = bus.MemReq & ~bus.IorD;
        if (sig && !prev_sig) begin
            if (armed && lat_q.size() > 0) check("latency", 32'(lat_cnt), 32'(lat_q.pop_front()));
            lat_cnt = 1;
            armed   = 1'b1;
        end else begin
            lat_cnt++;
        end
        prev_sig = sig;
    endtask

    // One clock: drive at posedge+1, compare at negedge, return at next posedge+1
    task automatic run_cycle(input phase_t ph, input logic rdy, input logic z,
                             input logic [5:0] op, input logic ill);
        string tag;
        tag = ph.name();
        bus.MemReady = rdy;
        bus.Zero     = z;
        bus.Opcode   = (ph == P_DECODE) ? op : 6'($urandom);
        @(negedge clk);
        track_latency();
        check(tag, 32'(obs_vec()), 32'(expect_vec(ph, rdy, z, ill)));
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input phase_t ph, input int waits, input logic [5:0] op);
        for (int i = 0; i < waits; i++) run_cycle(ph, 1'b0, 1'($urandom), op, 1'b0);
        run_cycle(ph, 1'b1, 1'($urandom), op, 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic bz);
        logic ill;
        int   lat;
        ill = !is_legal(op);
        lat = base_lat(op) + fw + ((op == T_LW || op == T_SW) ? mw : 0);
        lat_q.push_back(lat);
        mem_phase(P_FETCH, fw, op);
        run_cycle(P_DECODE, 1'($urandom), 1'($urandom), op, ill);
        case (op)
            T_LW: begin
                run_cycle(P_MEMADR, 1'($urandom), 1'($urandom), op, 1'b0);
                mem_phase(P_MEMRD, mw, op);
                run_cycle(P_MEMWB, 1'($urandom), 1'($urandom), op, 1'b0);
            end
            T_SW: begin
                run_cycle(P_MEMADR, 1'($urandom), 1'($urandom), op, 1'b0);
                mem_phase(P_MEMWR, mw, op);
            end
            T_RTYPE: begin
                run_cycle(P_EXEC,  1'($urandom), 1'($urandom), op, 1'b0);
                run_cycle(P_ALUWB, 1'($urandom), 1'($urandom), op, 1'b0);
            end
            T_BEQ:  run_cycle(P_BRANCH, 1'($urandom), bz, op, 1'b0);
            T_ADDI: begin
                run_cycle(P_ADDIEX, 1'($urandom), 1'($urandom), op, 1'b0);
                run_cycle(P_ADDIWB, 1'($urandom), 1'($urandom), op, 1'b0);
            end
            T_J:    run_cycle(P_JUMP, 1'($urandom), 1'($urandom), op, 1'b0);
            default: ;
        endcase
    endtask

    task automatic restart_tracking();
        prev_sig = 1'b0;
        armed    = 1'b0;
        lat_cnt  = 0;
        lat_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] pick [7];

        // Reset: FETCH values with MemReady masked
        rst_n = 1'b0;
        bus.MemReady = 1'b1;
        bus.Zero     = 1'b1;
        bus.Opcode   = T_LW;
        #2;
        check("reset", 32'(obs_vec()), 32'(expect_vec(P_FETCH, 1'b0, 1'b0, 1'b0)));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 32'(obs_vec()), 32'(expect_vec(P_FETCH, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        bus.MemReady = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        restart_tracking();

        // Directed cases
        run_instr(T_LW,    0, 2, 1'b0);
        run_instr(T_BEQ,   0, 0, 1'b1);
        run_instr(T_BEQ,   0, 0, 1'b0);
        run_instr(T_RTYPE, 0, 0, 1'b0);
        run_instr(T_SW,    0, 3, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(T_ADDI,  0, 0, 1'b0);
        run_instr(T_J,     2, 0, 1'b0);

        // Reset in the middle of a read access
        run_cycle(P_FETCH,  1'b1, 1'b0, T_LW, 1'b0);
        run_cycle(P_DECODE, 1'b0, 1'b0, T_LW, 1'b0);
        run_cycle(P_MEMADR, 1'b1, 1'b0, T_LW, 1'b0);
        run_cycle(P_MEMRD,  1'b0, 1'b0, T_LW, 1'b0);
        bus.MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_midaccess", 32'(obs_vec()), 32'(expect_vec(P_FETCH, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        bus.MemReady = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        restart_tracking();
        run_instr(T_ADDI, 1, 0, 1'b0);

        // Randomized instruction stream
        pick[0] = T_RTYPE; pick[1] = T_LW; pick[2] = T_SW; pick[3] = T_BEQ;
        pick[4] = T_ADDI;  pick[5] = T_J;  pick[6] = 6'b111111;
        for (int n = 0; n < 150; n++) begin
            int k;
            k = int'($urandom_range(0, 6));
            op = pick[k];
            if (k == 6) begin
                do op = 6'($urandom); while (is_legal(op));
            end
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end
        // Flush the final instruction's latency measurement
        run_cycle(P_FETCH, 1'b0, 1'b0, T_RTYPE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
